// File: rtl/hazard_fwd_unit_if.sv
// Bundle between the D/E/M/W pipeline registers and the hazard/forwarding unit.
// The unit itself connects through the slave modport; the pipeline datapath connects through the master modport.
interface hazard_fwd_unit_if;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_tuse_rs;
  logic [1:0]  D_tuse_rt;
  logic        D_we;
  logic [4:0]  D_wa;
  logic [1:0]  D_tnew;
  logic [31:0] D_grf_rd1;
  logic [31:0] D_grf_rd2;
  logic [31:0] E_rd1;
  logic [31:0] E_rd2;
  logic [31:0] E_fwd_src;
  logic [31:0] M_fwd_src;
  logic [31:0] W_fwd_src;
  logic        stall;
  logic [31:0] D_rs_val;
  logic [31:0] D_rt_val;
  logic [31:0] E_rs_val;
  logic [31:0] E_rt_val;
  logic [31:0] stall_cnt;

  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_we, D_wa, D_tnew,
    output D_grf_rd1, D_grf_rd2, E_rd1, E_rd2, E_fwd_src, M_fwd_src, W_fwd_src,
    input  stall, D_rs_val, D_rt_val, E_rs_val, E_rt_val, stall_cnt
  );

  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_we, D_wa, D_tnew,
    input  D_grf_rd1, D_grf_rd2, E_rd1, E_rd2, E_fwd_src, M_fwd_src, W_fwd_src,
    output stall, D_rs_val, D_rt_val, E_rs_val, E_rt_val, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Central hazard unit of the five-stage MIPS pipeline: Tnew/Tuse stall detection
// plus operand forwarding for the D-stage branch compare and the E-stage ALU inputs.
module hazard_fwd_unit (
  input  logic            clk,
  input  logic            reset,
  hazard_fwd_unit_if.slave bus
);
  localparam int DATA_W = 32;

  typedef struct packed {
    logic       vld;
    logic [4:0] addr;
    logic [1:0] tnew;
  } sb_rec_t;

  localparam sb_rec_t REC_NONE = '0;

  // Scoreboard: _p0 = E stage, _p1 = M stage, _p2 = W stage
  sb_rec_t             sb_e_p0;
  sb_rec_t             sb_m_p1;
  sb_rec_t             sb_w_p2;
  logic [4:0]          esrc_rs_p0;
  logic [4:0]          esrc_rt_p0;
  logic [DATA_W-1:0]   stall_cnt_q;
  logic                stall;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A record written to $0 never produces a value anyone can consume.
  function automatic logic rec_hit(input sb_rec_t rec, input logic [4:0] r);
    return rec.vld && (rec.addr != 5'd0) && (rec.addr == r);
  endfunction

  function automatic logic opnd_stall(input logic [4:0] r, input logic [1:0] tuse,
                                      input sb_rec_t se, input sb_rec_t sm);
    return (tuse != 2'd3) && (r != 5'd0) &&
           ((rec_hit(se, r) && (se.tnew > tuse)) || (rec_hit(sm, r) && (sm.tnew > tuse)));
  endfunction

  // Youngest match decides; a match whose value is not ready yet blocks older stages.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [4:0] r,
                                                input sb_rec_t se, input sb_rec_t sm,
                                                input sb_rec_t sw,
                                                input logic [DATA_W-1:0] e_src,
                                                input logic [DATA_W-1:0] m_src,
                                                input logic [DATA_W-1:0] w_src,
                                                input logic [DATA_W-1:0] fallback);
    if (rec_hit(se, r))      return (se.tnew == 2'd0) ? e_src : fallback;
    else if (rec_hit(sm, r)) return (sm.tnew == 2'd0) ? m_src : fallback;
    else if (rec_hit(sw, r)) return (sw.tnew == 2'd0) ? w_src : fallback;
    else                     return fallback;
  endfunction

  assign stall = opnd_stall(bus.D_rs, bus.D_tuse_rs, sb_e_p0, sb_m_p1) |
                 opnd_stall(bus.D_rt, bus.D_tuse_rt, sb_e_p0, sb_m_p1);

  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_q;

  assign bus.D_rs_val = fwd_sel(bus.D_rs, sb_e_p0, sb_m_p1, sb_w_p2,
                                bus.E_fwd_src, bus.M_fwd_src, bus.W_fwd_src, bus.D_grf_rd1);
  assign bus.D_rt_val = fwd_sel(bus.D_rt, sb_e_p0, sb_m_p1, sb_w_p2,
                                bus.E_fwd_src, bus.M_fwd_src, bus.W_fwd_src, bus.D_grf_rd2);

  // The E-stage operand cannot take its own result, so the E record is masked out.
  assign bus.E_rs_val = fwd_sel(esrc_rs_p0, REC_NONE, sb_m_p1, sb_w_p2,
                                bus.E_fwd_src, bus.M_fwd_src, bus.W_fwd_src, bus.E_rd1);
  assign bus.E_rt_val = fwd_sel(esrc_rt_p0, REC_NONE, sb_m_p1, sb_w_p2,
                                bus.E_fwd_src, bus.M_fwd_src, bus.W_fwd_src, bus.E_rd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_e_p0     <= REC_NONE;
      sb_m_p1     <= REC_NONE;
      sb_w_p2     <= REC_NONE;
      esrc_rs_p0  <= 5'd0;
      esrc_rt_p0  <= 5'd0;
      stall_cnt_q <= '0;
    end else begin
      sb_w_p2 <= {sb_m_p1.vld, sb_m_p1.addr, tnew_dec(sb_m_p1.tnew)};
      sb_m_p1 <= {sb_e_p0.vld, sb_e_p0.addr, tnew_dec(sb_e_p0.tnew)};
      if (stall) begin
        sb_e_p0     <= REC_NONE;
        esrc_rs_p0  <= 5'd0;
        esrc_rt_p0  <= 5'd0;
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        sb_e_p0     <= {bus.D_we, bus.D_wa, bus.D_tnew};
        esrc_rs_p0  <= bus.D_rs;
        esrc_rt_p0  <= bus.D_rt;
      end
    end
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed hazard scenarios followed by random traffic,
// compared against a model that tracks each in-flight write by its absolute ready cycle.
module tb_hazard_fwd_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_fwd_unit_if bus();
  hazard_fwd_unit dut (.clk(clk), .reset(reset), .bus(bus));

  // Model: what entered E at each cycle, and the cycle at which its result is ready.
  typedef struct {
    bit       vld;
    bit [4:0] addr;
    int       ready;
    bit [4:0] rs;
    bit [4:0] rt;
  } ent_t;

  ent_t        hist [4];
  int          cyc;
  int          checks;
  int          errors;
  int unsigned exp_cnt;

  function automatic ent_t bubble();
    ent_t e;
    e.vld = 0; e.addr = 0; e.ready = 0; e.rs = 0; e.rt = 0;
    return e;
  endfunction

  // k = 0 -> in E this cycle, 1 -> M, 2 -> W
  function automatic ent_t at_stage(int k);
    return hist[(cyc - k) & 3];
  endfunction

  function automatic int remaining(ent_t e);
    return (e.ready > cyc) ? e.ready - cyc : 0;
  endfunction

  function automatic bit hit(ent_t e, bit [4:0] r);
    return e.vld && (e.addr == r) && (r != 0);
  endfunction

  function automatic bit need_stall(bit [4:0] r, bit [1:0] tuse);
    if (tuse == 3 || r == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (hit(at_stage(k), r) && remaining(at_stage(k)) > int'(tuse)) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] fwd(bit [4:0] r, int first, logic [31:0] fb);
    logic [31:0] src [3];
    src[0] = bus.E_fwd_src;
    src[1] = bus.M_fwd_src;
    src[2] = bus.W_fwd_src;
    for (int k = first; k < 3; k++)
      if (hit(at_stage(k), r)) return (remaining(at_stage(k)) == 0) ? src[k] : fb;
    return fb;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit [4:0] rs, input bit [4:0] rt, input bit [1:0] tu_rs,
                       input bit [1:0] tu_rt, input bit we, input bit [4:0] wa,
                       input bit [1:0] tnew);
    bus.D_rs = rs;  bus.D_rt = rt;
    bus.D_tuse_rs = tu_rs;  bus.D_tuse_rt = tu_rt;
    bus.D_we = we;  bus.D_wa = wa;  bus.D_tnew = tnew;
    bus.D_grf_rd1 = $urandom;  bus.D_grf_rd2 = $urandom;
    bus.E_rd1 = $urandom;      bus.E_rd2 = $urandom;
    bus.E_fwd_src = $urandom;  bus.M_fwd_src = $urandom;  bus.W_fwd_src = $urandom;
  endtask

  task automatic model_edge(input bit es);
    ent_t n;
    n = bubble();
    if (reset) begin
      for (int i = 0; i < 4; i++) hist[i] = bubble();
      exp_cnt = 0;
    end else if (es) begin
      exp_cnt++;
    end else begin
      n.vld = bus.D_we; n.addr = bus.D_wa; n.ready = cyc + 1 + int'(bus.D_tnew);
      n.rs = bus.D_rs;  n.rt = bus.D_rt;
    end
    cyc++;
    if (!reset) hist[cyc & 3] = n;
  endtask

  // Check all outputs for the cycle, then clock once; called at the negative edge.
  task automatic step(output bit st);
    bit es;
    #1;
    es = need_stall(bus.D_rs, bus.D_tuse_rs) | need_stall(bus.D_rt, bus.D_tuse_rt);
    chk("stall", bus.stall, es);
    chk("D_rs_val", bus.D_rs_val, fwd(bus.D_rs, 0, bus.D_grf_rd1));
    chk("D_rt_val", bus.D_rt_val, fwd(bus.D_rt, 0, bus.D_grf_rd2));
    chk("E_rs_val", bus.E_rs_val, fwd(at_stage(0).rs, 1, bus.E_rd1));
    chk("E_rt_val", bus.E_rt_val, fwd(at_stage(0).rt, 1, bus.E_rd2));
    chk("stall_cnt", bus.stall_cnt, exp_cnt);
    st = bus.stall;
    @(posedge clk);
    model_edge(es);
    @(negedge clk);
  endtask

  // Present one instruction in D and hold it until the DUT lets it go; returns stall cycles.
  task automatic issue(input bit [4:0] rs, input bit [4:0] rt, input bit [1:0] tu_rs,
                       input bit [1:0] tu_rt, input bit we, input bit [4:0] wa,
                       input bit [1:0] tnew, output int nst);
    bit st;
    bit done;
    nst = 0;
    done = 0;
    for (int i = 0; i < 6; i++) begin
      drive(rs, rt, tu_rs, tu_rt, we, wa, tnew);
      step(st);
      if (!st) begin
        done = 1;
        break;
      end
      nst++;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL issue_timeout observed=stalled expected=released");
    end
  endtask

  task automatic flush();
    int n;
    for (int i = 0; i < 3; i++) issue(0, 0, 3, 3, 0, 0, 0, n);
  endtask

  initial begin
    int n;
    bit st;
    checks = 0; errors = 0; exp_cnt = 0; cyc = 0;
    for (int i = 0; i < 4; i++) hist[i] = bubble();

    reset = 1'b1;
    drive(0, 0, 3, 3, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Empty scoreboard: no stall, GRF value passes through.
    drive(5, 0, 0, 3, 0, 0, 0);
    step(st);
    chk("idle_no_stall", {31'd0, st}, 32'd0);

    // ALU producer then tuse-0 consumer.
    issue(1, 2, 1, 1, 1, 8, 1, n);
    issue(8, 0, 0, 3, 0, 0, 0, n);
    chk("alu_stall_cycles", n, 1);
    chk("alu_stall_cnt", bus.stall_cnt, 1);
    flush();

    // Load then tuse-1 consumer; the following flush checks E_rs_val from W.
    issue(1, 0, 1, 3, 1, 9, 2, n);
    issue(9, 0, 1, 3, 0, 0, 0, n);
    chk("load_tuse1_stalls", n, 1);
    flush();

    // Load then tuse-0 consumer.
    issue(1, 0, 1, 3, 1, 9, 2, n);
    issue(0, 9, 3, 0, 0, 0, 0, n);
    chk("load_tuse0_stalls", n, 2);
    flush();

    // jal then tuse-0 consumer of $31.
    issue(0, 0, 3, 3, 1, 31, 0, n);
    issue(31, 0, 0, 3, 0, 0, 0, n);
    chk("jal_stalls", n, 0);
    flush();

    // Writes to $0 never cause hazards.
    issue(0, 0, 3, 3, 1, 0, 2, n);
    issue(0, 0, 0, 0, 0, 0, 0, n);
    chk("zero_reg_stalls", n, 0);
    flush();

    // Two producers of $3; the younger one must win.
    issue(0, 0, 3, 3, 1, 3, 0, n);
    issue(0, 0, 3, 3, 1, 3, 0, n);
    issue(3, 3, 0, 0, 0, 0, 0, n);
    chk("double_prod_stalls", n, 0);
    flush();

    // Same register on both operands of a stalled consumer.
    issue(0, 0, 3, 3, 1, 7, 1, n);
    issue(7, 7, 0, 0, 0, 0, 0, n);
    chk("rs_eq_rt_stalls", n, 1);
    flush();

    // Reset during a stall.
    issue(0, 0, 3, 3, 1, 10, 2, n);
    drive(10, 0, 0, 3, 0, 0, 0);
    step(st);
    chk("mid_stall_seen", {31'd0, st}, 32'd1);
    reset = 1'b1;
    step(st);
    reset = 1'b0;
    #1;
    chk("post_reset_stall", {31'd0, bus.stall}, 32'd0);
    chk("post_reset_cnt", bus.stall_cnt, 32'd0);
    step(st);

    // Random traffic over a small register window to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 2)));
      step(st);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
